// File: rtl/bcd_conv_scheduler.sv
// bcd_conv_scheduler
//   Shares one bit-serial double-dabble binary-to-BCD engine between NUM_REQ
//   requesters. An arbiter picks one request while idle and captures its
//   operand. The engine then runs WIDTH add-3/shift iterations, one per clock.
//   The digits are returned with the index of the requester that asked for them.
//
//   Optional build macro: BCD_SCHED_FIXED_PRIO_EN
//     defined   -> fixed priority, where the lowest index wins and there is no
//                  rotating pointer
//     undefined -> round-robin, scanning from rr_ptr upward
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]        request i valid
//   req_data   in   [NUM_REQ*WIDTH]  operand i at [i*WIDTH +: WIDTH]
//   req_ready  out  [NUM_REQ]        one-hot grant while IDLE
//   out_valid  out                   result valid (DONE state)
//   out_ready  in                    consumer accepts result
//   out_bcd    out  [DIGITS*4]       digit k at [4k+3:4k], digit 0 = ones
//   out_id     out  [ID_W]           requester index of out_bcd
//   busy       out                   high whenever not IDLE
//
// State table
//   IDLE  | arbitrating; accepts one request per edge
//   SHIFT | one add-3/shift iteration per edge, WIDTH in total
//   DONE  | result presented until out_ready handshake
module bcd_conv_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int DIGITS  = 3,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DIGITS*4-1:0]        out_bcd,
  output logic [ID_W-1:0]            out_id,
  output logic                       busy
);

  localparam int BCD_W = DIGITS * 4;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SR_W-1:0]    r_sr;
  logic [SR_W-1:0]    w_sr_adj;
  logic [SR_W-1:0]    w_sr_step;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   r_out_bcd;
  logic [ID_W-1:0]    r_out_id;
  logic [ID_W-1:0]    w_winner;
  logic               w_any;
  logic               w_accept;
  logic               w_last_iter;
  logic [WIDTH-1:0]   w_operand;

`ifndef BCD_SCHED_FIXED_PRIO_EN
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    w_rr_nxt;
`endif

  // Arbiter. The loop scans from the lowest priority down to the highest, so
  // the last match it records is the highest-priority requester.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
`ifdef BCD_SCHED_FIXED_PRIO_EN
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        w_any    = 1'b1;
        w_winner = ID_W'(k);
      end
    end
`else
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_any    = 1'b1;
        w_winner = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
`endif
  end

`ifndef BCD_SCHED_FIXED_PRIO_EN
  assign w_rr_nxt = (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
`endif

  assign w_accept    = (r_state == ST_IDLE) && w_any;
  assign w_operand   = req_data[int'(w_winner) * WIDTH +: WIDTH];
  assign w_last_iter = (r_cnt == CNT_W'(WIDTH - 1));

  // One double-dabble iteration: add 3 to every digit >= 5 (4-bit wrap), then shift left.
  always_comb begin
    w_sr_adj = r_sr;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_sr[WIDTH + 4*d +: 4] >= 4'd5) begin
        w_sr_adj[WIDTH + 4*d +: 4] = r_sr[WIDTH + 4*d +: 4] + 4'd3;
      end
    end
    w_sr_step = {w_sr_adj[SR_W-2:0], 1'b0};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and FSM outputs
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_accept) begin
          req_ready[w_winner] = 1'b1;
          w_state_nxt         = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_last_iter) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr      <= '0;
      r_cnt     <= '0;
      r_out_bcd <= '0;
      r_out_id  <= '0;
`ifndef BCD_SCHED_FIXED_PRIO_EN
      r_rr_ptr  <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sr     <= {{BCD_W{1'b0}}, w_operand};
            r_cnt    <= '0;
            r_out_id <= w_winner;
`ifndef BCD_SCHED_FIXED_PRIO_EN
            r_rr_ptr <= w_rr_nxt;
`endif
          end
        end
        ST_SHIFT: begin
          r_sr  <= w_sr_step;
          r_cnt <= r_cnt + 1'b1;
          // The result register keeps the last result while a new conversion
          // reuses the shift register.
          if (w_last_iter) begin
            r_out_bcd <= w_sr_step[SR_W-1 -: BCD_W];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_bcd = r_out_bcd;
  assign out_id  = r_out_id;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
module tb_bcd_conv_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_bcd;
  logic [1:0]  out_id;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  bcd_conv_scheduler #(.NUM_REQ(4), .WIDTH(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  exp_ready;
    logic [1:0]  exp_id;
    logic [11:0] exp_bcd;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered one time unit after a rising edge, with the DUT idle. Returns in
  // the same phase, after the result handshake.
  task automatic run_conv(input string tag, input logic [3:0] v, input logic [31:0] d,
                          input logic [3:0] er, input logic [1:0] eid, input logic [11:0] ebcd);
    int n;
    req_valid = v;
    req_data  = d;
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(er));
    if (er == 4'b0000) begin
      tick();
      tick();
      chk({tag, "_stay_idle"}, 32'(busy), 32'd0);
      req_valid = '0;
      return;
    end
    tick();
    req_valid = '0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd8);
    chk({tag, "_bcd"}, 32'(out_bcd), 32'(ebcd));
    chk({tag, "_id"}, 32'(out_id), 32'(eid));
    tick();
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_bcd_hold"}, 32'(out_bcd), 32'(ebcd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{4'b0010, 32'h0000FF00, 4'b0010, 2'd1, 12'h255};
    vecs[1] = '{4'b0000, 32'h00000000, 4'b0000, 2'd0, 12'h000};
    vecs[2] = '{4'b0001, 32'h00000000, 4'b0001, 2'd0, 12'h000};
    vecs[3] = '{4'b0001, 32'h00000063, 4'b0001, 2'd0, 12'h099};
    vecs[4] = '{4'b0010, 32'h00002A00, 4'b0010, 2'd1, 12'h042};
    vecs[5] = '{4'b1000, 32'hC8000000, 4'b1000, 2'd3, 12'h200};
`ifdef BCD_SCHED_FIXED_PRIO_EN
    for (int i = 6; i < 11; i++) vecs[i] = '{4'b1111, 32'h9D6B3907, 4'b0001, 2'd0, 12'h007};
`else
    vecs[6]  = '{4'b1111, 32'h9D6B3907, 4'b0001, 2'd0, 12'h007};
    vecs[7]  = '{4'b1111, 32'h9D6B3907, 4'b0010, 2'd1, 12'h057};
    vecs[8]  = '{4'b1111, 32'h9D6B3907, 4'b0100, 2'd2, 12'h107};
    vecs[9]  = '{4'b1111, 32'h9D6B3907, 4'b1000, 2'd3, 12'h157};
    vecs[10] = '{4'b1111, 32'h9D6B3907, 4'b0001, 2'd0, 12'h007};
`endif

    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_bcd", 32'(out_bcd), 32'd0);
    chk("rst_id", 32'(out_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      run_conv($sformatf("vec%0d", i), vecs[i].valid, vecs[i].data,
               vecs[i].exp_ready, vecs[i].exp_id, vecs[i].exp_bcd);
    end

    // Consumer stall: result must hold and no new request is accepted.
    out_ready = 1'b0;
    req_valid = 4'b0100;
    req_data  = 32'h007B0000;
    #1;
    chk("stall_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0001;
    req_data  = 32'h00000005;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("stall_latency", 32'(n), 32'd8);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("stall_valid_%0d", c), 32'(out_valid), 32'd1);
      chk($sformatf("stall_bcd_%0d", c), 32'(out_bcd), 32'h123);
      chk($sformatf("stall_id_%0d", c), 32'(out_id), 32'd2);
      chk($sformatf("stall_noaccept_%0d", c), 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("stall_release", 32'(out_valid), 32'd0);
    chk("stall_bcd_hold", 32'(out_bcd), 32'h123);
    chk("stall_id_hold", 32'(out_id), 32'd2);
    run_conv("after_stall", 4'b0001, 32'h00000005, 4'b0001, 2'd0, 12'h005);

    // Reset in the middle of a conversion.
    req_valid = 4'b0010;
    req_data  = 32'h00008000;
    #1;
    chk("midrst_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    for (int c = 0; c < 4; c++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_bcd", 32'(out_bcd), 32'd0);
    chk("midrst_id", 32'(out_id), 32'd0);
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (out_valid) n++;
    end
    chk("midrst_no_pulse", 32'(n), 32'd0);
    run_conv("post_rst", 4'b1111, 32'h80808080, 4'b0001, 2'd0, 12'h128);

`ifdef BCD_SCHED_FIXED_PRIO_EN
    for (int r = 0; r < 3; r++) begin
      run_conv($sformatf("fixprio%0d", r), 4'b0101, 32'h004D0021, 4'b0001, 2'd0, 12'h033);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
